// File: rtl/robo_pkg.sv
// Shared definitions for the grid robot: heading/action encodings, controller
// state enum and the heading rotation / move-code helpers.
package robo_pkg;

  // Heading encoding on orientacao (note E/S order differs from the action codes)
  localparam logic [2:0] ORI_N = 3'b001;
  localparam logic [2:0] ORI_W = 3'b010;
  localparam logic [2:0] ORI_E = 3'b011;
  localparam logic [2:0] ORI_S = 3'b100;

  localparam logic [2:0] ACT_NONE = 3'b000;
  localparam logic [2:0] ACT_N    = 3'b001;
  localparam logic [2:0] ACT_W    = 3'b010;
  localparam logic [2:0] ACT_S    = 3'b011;
  localparam logic [2:0] ACT_E    = 3'b100;

  localparam logic [2:0] TURN_LIMIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SENSE = 3'd1,
    ST_EVAL  = 3'd2,
    ST_MOVE  = 3'd3,
    ST_DONE  = 3'd4,
    ST_STUCK = 3'd5
  } robo_state_t;

  function automatic logic [2:0] rot_left(input logic [2:0] ori);
    case (ori)
      ORI_N:   return ORI_W;
      ORI_W:   return ORI_S;
      ORI_S:   return ORI_E;
      ORI_E:   return ORI_N;
      default: return ORI_N;
    endcase
  endfunction

  function automatic logic [2:0] rot_right(input logic [2:0] ori);
    case (ori)
      ORI_N:   return ORI_E;
      ORI_E:   return ORI_S;
      ORI_S:   return ORI_W;
      ORI_W:   return ORI_N;
      default: return ORI_N;
    endcase
  endfunction

  function automatic logic [2:0] ori2acao(input logic [2:0] ori);
    case (ori)
      ORI_N:   return ACT_N;
      ORI_W:   return ACT_W;
      ORI_S:   return ACT_S;
      ORI_E:   return ACT_E;
      default: return ACT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/robo_controle.sv
// Left-hand wall-following controller: sense/evaluate/move loop over the map
// block's head/left obstacle bits, ending on goal, step budget or enclosure.
module robo_controle
  import robo_pkg::*;
#(
  parameter int         STEP_W      = 16,
  parameter int         MAX_STEPS   = 1000,
  parameter logic [2:0] INIT_ORIENT = 3'b001
) (
  input  logic              clockc1,
  input  logic              reset,
  input  logic              start,
  input  logic              goal,
  input  logic              head,
  input  logic              left,
  output logic [2:0]        acao,
  output logic [2:0]        orientacao,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              stuck,
  output logic [STEP_W-1:0] step_count,
  output robo_state_t       dbg_state
);

  localparam logic [STEP_W-1:0] MAX_V  = STEP_W'(MAX_STEPS);
  localparam bit                TO_EN  = (MAX_STEPS != 0);

  robo_state_t       r_state;
  logic [2:0]        r_acao;
  logic [2:0]        r_ori;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;
  logic              r_stuck;
  logic [STEP_W-1:0] r_step;
  logic [2:0]        r_turns;

  robo_state_t       w_state_nx;
  logic [2:0]        w_acao_nx;
  logic [2:0]        w_ori_nx;
  logic              w_done_nx;
  logic              w_timeout_nx;
  logic              w_stuck_nx;
  logic [STEP_W-1:0] w_step_nx;
  logic [2:0]        w_turns_nx;
  logic              w_busy_nx;

  logic [2:0]        w_ori_left;
  logic [2:0]        w_ori_right;
  logic [2:0]        w_turns_inc;
  logic [STEP_W-1:0] w_step_inc;
  logic              w_to_hit;

  assign w_ori_left  = rot_left(r_ori);
  assign w_ori_right = rot_right(r_ori);
  assign w_turns_inc = r_turns + 3'd1;
  assign w_step_inc  = (&r_step) ? r_step : r_step + 1'b1;
  // A zero budget disables the timeout; only saturation bounds the count.
  assign w_to_hit    = TO_EN && (w_step_inc == MAX_V);

  always_comb begin
    w_state_nx   = r_state;
    w_acao_nx    = ACT_NONE;
    w_ori_nx     = r_ori;
    w_done_nx    = r_done;
    w_timeout_nx = r_timeout;
    w_stuck_nx   = r_stuck;
    w_step_nx    = r_step;
    w_turns_nx   = r_turns;
    case (r_state)
      ST_IDLE, ST_DONE, ST_STUCK: begin
        if (start) begin
          w_state_nx   = ST_SENSE;
          w_done_nx    = 1'b0;
          w_timeout_nx = 1'b0;
          w_stuck_nx   = 1'b0;
          w_step_nx    = '0;
          w_turns_nx   = 3'd0;
        end
      end
      ST_SENSE: w_state_nx = ST_EVAL;
      ST_EVAL: begin
        if (goal) begin
          w_state_nx = ST_DONE;
          w_done_nx  = 1'b1;
        end else if (!left) begin
          w_ori_nx   = w_ori_left;
          w_acao_nx  = ori2acao(w_ori_left);
          w_turns_nx = 3'd0;
          w_state_nx = ST_MOVE;
        end else if (!head) begin
          w_acao_nx  = ori2acao(r_ori);
          w_turns_nx = 3'd0;
          w_state_nx = ST_MOVE;
        end else begin
          w_ori_nx   = w_ori_right;
          w_turns_nx = w_turns_inc;
          if (w_turns_inc == TURN_LIMIT) begin
            w_state_nx = ST_STUCK;
            w_stuck_nx = 1'b1;
          end else begin
            w_state_nx = ST_SENSE;
          end
        end
      end
      ST_MOVE: begin
        // The step is committed on the edge that leaves MOVE.
        w_step_nx = w_step_inc;
        if (w_to_hit) begin
          w_state_nx   = ST_DONE;
          w_done_nx    = 1'b1;
          w_timeout_nx = 1'b1;
        end else begin
          w_state_nx = ST_SENSE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_busy_nx = (w_state_nx == ST_SENSE) || (w_state_nx == ST_EVAL) ||
                (w_state_nx == ST_MOVE);
  end

  always_ff @(posedge clockc1 or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_acao    <= ACT_NONE;
      r_ori     <= INIT_ORIENT;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_stuck   <= 1'b0;
      r_step    <= '0;
      r_turns   <= 3'd0;
    end else begin
      r_state   <= w_state_nx;
      r_acao    <= w_acao_nx;
      r_ori     <= w_ori_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_timeout <= w_timeout_nx;
      r_stuck   <= w_stuck_nx;
      r_step    <= w_step_nx;
      r_turns   <= w_turns_nx;
    end
  end

  assign acao       = r_acao;
  assign orientacao = r_ori;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign stuck      = r_stuck;
  assign step_count = r_step;
  assign dbg_state  = r_state;

endmodule

// File: doc/robo_controle.md
# robo_controle

Left-hand wall-following navigation controller for the grid robot. It is the initiator on the map interface: it drives `acao` (move command) and `orientacao` (heading) into the map block, and it reads back the map's registered `head` and `left` obstacle bits. It runs a sense/evaluate/move state machine until one of three conditions ends the run: goal reached, step budget exhausted, or robot enclosed.

## Interface
- `STEP_W`, default 16: width of the step counter.
- `MAX_STEPS`, default 1000: move budget. Reaching it ends the run with `timeout`.
- `INIT_ORIENT`, default 3'b001: heading loaded at reset.

- `clockc1`  in  1: single clock. All state updates occur on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `start`  in  1: begin or restart a run. Honoured only in IDLE, DONE or STUCK.
- `goal`  in  1: robot is on the target cell. Sampled in EVAL.
- `head`  in  1: obstacle ahead, from the map block. 1 = blocked.
- `left`  in  1: obstacle on the left, from the map block. 1 = blocked.
- `acao`  out  3: move command. 000 = none, 001 = N, 010 = W, 011 = S, 100 = E.
- `orientacao`  out  3: heading. 001 = N, 010 = W, 011 = E, 100 = S.
- `busy`  out  1: a run is in progress.
- `done`  out  1: run ended by goal or timeout.
- `timeout`  out  1: run ended because `MAX_STEPS` was reached.
- `stuck`  out  1: four consecutive right turns occurred with no move.
- `step_count`  out  STEP_W: number of moves made in the current run. Saturating.

## Operation
- Encoding caution: the two ports use different encodings. In `orientacao`, 011 = E and 100 = S. In `acao`, 011 = S and 100 = E.
- Move mapping from heading to `acao`: N→001, W→010, S→011, E→100.
- Left rotation: N→W→S→E→N.
- Right rotation: N→E→S→W→N.
- All outputs are registered.
- States: IDLE, SENSE, EVAL, MOVE, DONE, STUCK.
- IDLE
  - `acao` = 000, `busy` = 0.
  - `start` = 1 → SENSE. On this transition, clear `step_count`, the turn counter, `done`, `timeout` and `stuck`.
- SENSE
  - `acao` = 000, `orientacao` stable.
  - The map samples the heading on this edge. Always → EVAL.
- EVAL: `head` and `left` are valid for the current heading. Decide in this priority order:
  - `goal` = 1 → DONE, with `done` = 1.
  - else `left` = 0 → rotate heading left, clear turn counter, → MOVE.
  - else `head` = 0 → keep heading, clear turn counter, → MOVE.
  - else rotate heading right and increment turn counter. If the counter reaches 4 → STUCK with `stuck` = 1; otherwise → SENSE.
- MOVE
  - `acao` = move code of the current `orientacao`, asserted for exactly one cycle.
  - `step_count` increments, saturating at all-ones.
  - If the incremented value equals `MAX_STEPS` → DONE with `done` = 1 and `timeout` = 1; otherwise → SENSE.
- DONE / STUCK
  - `acao` = 000, `busy` = 0, flags held.
  - `start` = 1 → SENSE, with the same clears as the IDLE transition. `orientacao` is kept, because the robot does not physically turn.
- `busy` = 1 exactly in SENSE, EVAL and MOVE.
- `start` while `busy` = 1 is ignored.

## Timing
- Reset values:
  - `acao` = 000, `orientacao` = `INIT_ORIENT`.
  - `busy`, `done`, `timeout`, `stuck` all 0; `step_count` = 0.
  - State = IDLE; turn counter = 0.
- Start to first `acao`: `start` is sampled at edge 0; SENSE occupies cycle 1, EVAL cycle 2, MOVE cycle 3.
- Forward or left-turn step: 3 cycles (SENSE, EVAL, MOVE).
- Each right turn adds 2 cycles (SENSE, EVAL) with `acao` = 000.
- Worst case before STUCK: 8 cycles after SENSE entry.
- The map's `head`/`left` lag its input by one edge. EVAL is the earliest cycle in which they are used.
- `goal` and `head`/`left` are ignored outside EVAL.
- `goal` = 1 together with `left` = 0 → DONE. No move is issued.
- Reset asserted mid-MOVE: `acao` returns to 000 asynchronously and the step is not counted.
- `MAX_STEPS` = 0: the timeout compare never matches; only saturation limits `step_count`.

## Structure
- Package `robo_pkg`, shared with the map block:
  - Heading constants ORI_N/ORI_W/ORI_E/ORI_S.
  - Action constants ACT_NONE/ACT_N/ACT_W/ACT_S/ACT_E.
  - State enum.
  - Functions `rot_left`, `rot_right`, `ori2acao`.
- No sub-module: a single FSM plus a 3-bit turn counter and the `step_count` register.

## Test plan
- Reset check: hold `reset` = 0, then release.
  - → `acao` = 000, `orientacao` = 001, `busy` = 0, `step_count` = 0, state IDLE.
- Straight corridor: `head` = 0, `left` = 1, pulse `start`.
  - → `acao` = 001 in cycles 3, 6, 9.
  - → `orientacao` stays 001; `step_count` = 3 after cycle 9.
- Left opening: heading N, `left` = 0 in EVAL.
  - → `orientacao` = 010 and `acao` = 010 in the next cycle; turn counter cleared.
- Enclosed cell: `head` = 1, `left` = 1 constantly from N.
  - → `orientacao` steps 011, 100, 010, 001.
  - → `stuck` = 1 after the 4th EVAL; `acao` never leaves 000; `step_count` = 0.
- Goal priority: `goal` = 1 with `left` = 0 in EVAL.
  - → `done` = 1, `busy` = 0, no MOVE.
  - → a new `start` clears `done` and resumes from SENSE with the heading kept.
- Timeout and reset: `MAX_STEPS` = 3 in an open corridor.
  - → `done` = 1 and `timeout` = 1 after the 3rd MOVE.
  - Separately, assert `reset` during a MOVE → `acao` = 000 immediately and `step_count` = 0.
